// File: rtl/mem_access_pkg.sv
// Shared instruction codes, access lengths and bus widths
// for the memory access stage.
package mem_access_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int INST_W     = 8;
   localparam int CSR_ADDR_W = 12;

   localparam logic [INST_W-1:0] INST_NOP = 8'h00;
   localparam logic [INST_W-1:0] INST_ADD = 8'h01;
   localparam logic [INST_W-1:0] INST_LB  = 8'h10;
   localparam logic [INST_W-1:0] INST_LH  = 8'h11;
   localparam logic [INST_W-1:0] INST_LW  = 8'h12;
   localparam logic [INST_W-1:0] INST_LBU = 8'h13;
   localparam logic [INST_W-1:0] INST_LHU = 8'h14;
   localparam logic [INST_W-1:0] INST_SB  = 8'h18;
   localparam logic [INST_W-1:0] INST_SH  = 8'h19;
   localparam logic [INST_W-1:0] INST_SW  = 8'h1A;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   function automatic logic is_mem_op(input logic [INST_W-1:0] inst);
      return inst inside {INST_LB, INST_LH, INST_LW, INST_LBU,
                          INST_LHU, INST_SB, INST_SH, INST_SW};
   endfunction

   function automatic logic is_store(input logic [INST_W-1:0] inst);
      return inst inside {INST_SB, INST_SH, INST_SW};
   endfunction

   function automatic logic [1:0] len_of(input logic [INST_W-1:0] inst);
      logic [1:0] len;
      case (inst)
         INST_LB, INST_LBU, INST_SB: len = LEN_BYTE;
         INST_LH, INST_LHU, INST_SH: len = LEN_HALF;
         default:                    len = LEN_WORD;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load data extension: picks byte/half/word from the raw
// read data and sign- or zero-extends it.
module mem_load_ext
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [INST_W-1:0] inst,
   input  logic [DATA_W-1:0] raw,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = raw;
      case (inst)
         INST_LB:  data = {{(DATA_W-8){raw[7]}}, raw[7:0]};
         INST_LBU: data = {{(DATA_W-8){1'b0}}, raw[7:0]};
         INST_LH:  data = {{(DATA_W-16){raw[15]}}, raw[15:0]};
         INST_LHU: data = {{(DATA_W-16){1'b0}}, raw[15:0]};
         default:  data = raw;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory access stage: issues one request per load/store,
// holds the pipeline until the controller completes it.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic [REG_ADDR_W-1:0] rd_address_in,
   input  logic [DATA_W-1:0]     rd_data_in,
   input  logic [INST_W-1:0]     inst_in,
   input  logic [ADDR_W-1:0]     mem_address_in,
   input  logic [CSR_ADDR_W-1:0] csr_in,
   input  logic                  csr_write_enable_in,
   input  logic [DATA_W-1:0]     csr_write_data_in,
   output logic [CSR_ADDR_W-1:0] csr_out,
   output logic                  csr_write_enable_out,
   output logic [DATA_W-1:0]     csr_write_data_out,
   output logic [REG_ADDR_W-1:0] rd_address_out,
   output logic [DATA_W-1:0]     rd_data_out,
   output logic                  stall_req_out,
   output logic                  mem_req_out,
   output logic                  mem_we_out,
   output logic [ADDR_W-1:0]     mem_addr_out,
   output logic [DATA_W-1:0]     mem_wdata_out,
   output logic [1:0]            mem_len_out,
   input  logic                  mem_busy_in,
   input  logic                  mem_done_in,
   input  logic [DATA_W-1:0]     mem_rdata_in
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] ext_data;
   logic              mem_op;
   logic              store;
   logic              issue;

   assign mem_op = is_mem_op(inst_in);
   assign store  = is_store(inst_in);
   // Never issue while frozen: the state could not advance to WAIT.
   assign issue  = (state == IDLE) && mem_op && !mem_busy_in && rdy_in;

   assign mem_req_out   = rst_in && (issue || state == WAIT);
   assign mem_we_out    = mem_req_out && store;
   assign mem_addr_out  = mem_req_out ? mem_address_in : '0;
   assign mem_wdata_out = mem_we_out ? rd_data_in : '0;
   assign mem_len_out   = mem_req_out ? len_of(inst_in) : LEN_BYTE;
   assign stall_req_out = rst_in && mem_op && (state != DONE);

   assign csr_out              = rst_in ? csr_in : '0;
   assign csr_write_enable_out = rst_in && csr_write_enable_in;
   assign csr_write_data_out   = rst_in ? csr_write_data_in : '0;

   mem_load_ext #(.DATA_W(DATA_W)) u_ext (
      .inst (inst_in),
      .raw  (rdata_q),
      .data (ext_data)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (issue) state_nxt = WAIT;
         WAIT:    if (mem_done_in) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state   <= IDLE;
         rdata_q <= '0;
      end else if (rdy_in) begin
         state <= state_nxt;
         if (state == WAIT && mem_done_in)
            rdata_q <= mem_rdata_in;
      end
   end

   always_comb begin
      rd_address_out = '0;
      rd_data_out    = '0;
      if (rst_in) begin
         if (!mem_op) begin
            rd_address_out = rd_address_in;
            rd_data_out    = rd_data_in;
         end else if (!store) begin
            rd_address_out = rd_address_in;
            if (state == DONE)
               rd_data_out = ext_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, busy
// back-pressure, ready freeze and reset during an access.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [4:0]  rd_address_in;
   logic [31:0] rd_data_in;
   logic [7:0]  inst_in;
   logic [31:0] mem_address_in;
   logic [11:0] csr_in;
   logic        csr_write_enable_in;
   logic [31:0] csr_write_data_in;
   logic [11:0] csr_out;
   logic        csr_write_enable_out;
   logic [31:0] csr_write_data_out;
   logic [4:0]  rd_address_out;
   logic [31:0] rd_data_out;
   logic        stall_req_out;
   logic        mem_req_out;
   logic        mem_we_out;
   logic [31:0] mem_addr_out;
   logic [31:0] mem_wdata_out;
   logic [1:0]  mem_len_out;
   logic        mem_busy_in;
   logic        mem_done_in;
   logic [31:0] mem_rdata_in;

   int errors = 0;
   int checks = 0;

   logic [31:0] r_data;
   logic [4:0]  r_addr;
   logic [1:0]  r_len;
   logic        r_we;
   logic [31:0] r_wdata;
   logic [31:0] r_maddr;
   logic        r_done_req;
   int          r_stalls;
   int          r_reqs;
   int          r_req_cyc;
   bit          r_ok;

   mem_access dut (
      .clk_in               (clk),
      .rst_in               (rst_in),
      .rdy_in               (rdy_in),
      .rd_address_in        (rd_address_in),
      .rd_data_in           (rd_data_in),
      .inst_in              (inst_in),
      .mem_address_in       (mem_address_in),
      .csr_in               (csr_in),
      .csr_write_enable_in  (csr_write_enable_in),
      .csr_write_data_in    (csr_write_data_in),
      .csr_out              (csr_out),
      .csr_write_enable_out (csr_write_enable_out),
      .csr_write_data_out   (csr_write_data_out),
      .rd_address_out       (rd_address_out),
      .rd_data_out          (rd_data_out),
      .stall_req_out        (stall_req_out),
      .mem_req_out          (mem_req_out),
      .mem_we_out           (mem_we_out),
      .mem_addr_out         (mem_addr_out),
      .mem_wdata_out        (mem_wdata_out),
      .mem_len_out          (mem_len_out),
      .mem_busy_in          (mem_busy_in),
      .mem_done_in          (mem_done_in),
      .mem_rdata_in         (mem_rdata_in)
   );

   always #5 clk = ~clk;

   // Runs one access, answering the request with a done pulse
   // in the first WAIT cycle; records what was observed.
   task automatic run_access(input logic [7:0] inst,
                             input logic [31:0] addr,
                             input logic [31:0] wd,
                             input logic [31:0] rdata,
                             input int busy_cycles);
      int  busy_left;
      bit  prev;
      bit  pulsed;
      busy_left = busy_cycles;
      prev = 0;
      pulsed = 0;
      r_ok = 0;
      r_stalls = 0;
      r_reqs = 0;
      r_req_cyc = 0;
      @(posedge clk); #1;
      inst_in = inst;
      mem_address_in = addr;
      rd_data_in = wd;
      rd_address_in = 5'd9;
      mem_rdata_in = rdata;
      mem_done_in = 0;
      mem_busy_in = (busy_left > 0);
      for (int c = 1; c <= 20 && !r_ok; c++) begin
         @(negedge clk);
         if (c > 1 && !stall_req_out) begin
            r_ok = 1;
            r_data = rd_data_out;
            r_addr = rd_address_out;
            r_done_req = mem_req_out;
         end else begin
            if (stall_req_out) r_stalls++;
            if (mem_req_out && !prev) begin
               r_reqs++;
               if (r_reqs == 1) begin
                  r_req_cyc = c;
                  r_len = mem_len_out;
                  r_we = mem_we_out;
                  r_wdata = mem_wdata_out;
                  r_maddr = mem_addr_out;
               end
            end
            prev = mem_req_out;
            @(posedge clk); #1;
            mem_done_in = 0;
            if (r_reqs > 0 && !pulsed) begin
               mem_done_in = 1;
               pulsed = 1;
            end
            busy_left--;
            mem_busy_in = (busy_left > 0);
         end
      end
      checks++;
      if (!r_ok) begin
         errors++;
         $display("FAIL access_timeout inst=%h: no completion in 20 cycles", inst);
      end
      @(posedge clk); #1;
      inst_in = INST_NOP;
      mem_done_in = 0;
      mem_busy_in = 0;
   endtask

   task automatic test_reset;
      rst_in = 0;
      rdy_in = 1;
      inst_in = INST_LW;
      rd_address_in = 5'd7;
      rd_data_in = 32'h1234;
      mem_address_in = 32'h40;
      csr_in = 12'hABC;
      csr_write_enable_in = 1;
      csr_write_data_in = 32'h5A5A;
      mem_busy_in = 0;
      mem_done_in = 0;
      mem_rdata_in = 0;
      #12;
      checks++;
      if ({mem_req_out, mem_we_out, mem_len_out, stall_req_out} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {mem_req_out, mem_we_out, mem_len_out, stall_req_out});
      end
      checks++;
      if (mem_addr_out !== 0 || mem_wdata_out !== 0) begin
         errors++;
         $display("FAIL reset_bus addr=%h wdata=%h want 0", mem_addr_out, mem_wdata_out);
      end
      checks++;
      if (rd_address_out !== 0 || rd_data_out !== 0) begin
         errors++;
         $display("FAIL reset_rd addr=%h data=%h want 0", rd_address_out, rd_data_out);
      end
      checks++;
      if (csr_out !== 0 || csr_write_enable_out !== 0 || csr_write_data_out !== 0) begin
         errors++;
         $display("FAIL reset_csr got=%h/%b/%h want 0",
                  csr_out, csr_write_enable_out, csr_write_data_out);
      end
      inst_in = INST_NOP;
      @(posedge clk); #1;
      rst_in = 1;
   endtask

   task automatic test_passthrough;
      @(posedge clk); #1;
      inst_in = INST_NOP;
      rd_address_in = 5'd1;
      rd_data_in = 32'h11;
      #1;
      checks++;
      if (rd_address_out !== 5'd1 || rd_data_out !== 32'h11 ||
          stall_req_out !== 0 || mem_req_out !== 0) begin
         errors++;
         $display("FAIL nop_pass got rd=%0d data=%h stall=%b req=%b want 1/11/0/0",
                  rd_address_out, rd_data_out, stall_req_out, mem_req_out);
      end
      inst_in = INST_ADD;
      rd_address_in = 5'd5;
      rd_data_in = 32'd7;
      #1;
      checks++;
      if (rd_address_out !== 5'd5 || rd_data_out !== 32'd7 ||
          stall_req_out !== 0 || mem_req_out !== 0) begin
         errors++;
         $display("FAIL add_pass got rd=%0d data=%h stall=%b req=%b want 5/7/0/0",
                  rd_address_out, rd_data_out, stall_req_out, mem_req_out);
      end
      checks++;
      if (csr_out !== 12'hABC || csr_write_enable_out !== 1 ||
          csr_write_data_out !== 32'h5A5A) begin
         errors++;
         $display("FAIL csr_pass got=%h/%b/%h want abc/1/5a5a",
                  csr_out, csr_write_enable_out, csr_write_data_out);
      end
      inst_in = INST_NOP;
   endtask

   task automatic test_lb;
      run_access(INST_LB, 32'h1000, 32'h0, 32'h000000F0, 0);
      checks++;
      if (r_len !== LEN_BYTE || r_we !== 0 || r_maddr !== 32'h1000) begin
         errors++;
         $display("FAIL lb_req len=%b we=%b addr=%h want 00/0/1000", r_len, r_we, r_maddr);
      end
      checks++;
      if (r_data !== 32'hFFFFFFF0 || r_addr !== 5'd9) begin
         errors++;
         $display("FAIL lb_data got=%h rd=%0d want fffffff0/9", r_data, r_addr);
      end
      checks++;
      if (r_stalls != 2 || r_reqs != 1 || r_done_req !== 0) begin
         errors++;
         $display("FAIL lb_stall stalls=%0d reqs=%0d done_req=%b want 2/1/0",
                  r_stalls, r_reqs, r_done_req);
      end
      run_access(INST_LBU, 32'h1001, 32'h0, 32'h000000F0, 0);
      checks++;
      if (r_data !== 32'h000000F0) begin
         errors++;
         $display("FAIL lbu_data got=%h want 000000f0", r_data);
      end
   endtask

   task automatic test_half;
      run_access(INST_LHU, 32'h1002, 32'h0, 32'h12348001, 0);
      checks++;
      if (r_data !== 32'h00008001 || r_len !== LEN_HALF) begin
         errors++;
         $display("FAIL lhu_data got=%h len=%b want 00008001/01", r_data, r_len);
      end
      run_access(INST_LH, 32'h1002, 32'h0, 32'h12348001, 0);
      checks++;
      if (r_data !== 32'hFFFF8001 || r_len !== LEN_HALF) begin
         errors++;
         $display("FAIL lh_data got=%h len=%b want ffff8001/01", r_data, r_len);
      end
   endtask

   task automatic test_word;
      run_access(INST_SW, 32'h2004, 32'hDEADBEEF, 32'h0, 0);
      checks++;
      if (r_we !== 1 || r_len !== LEN_WORD || r_wdata !== 32'hDEADBEEF ||
          r_maddr !== 32'h2004) begin
         errors++;
         $display("FAIL sw_req we=%b len=%b wdata=%h addr=%h want 1/10/deadbeef/2004",
                  r_we, r_len, r_wdata, r_maddr);
      end
      checks++;
      if (r_addr !== 0 || r_data !== 0) begin
         errors++;
         $display("FAIL sw_rd got rd=%0d data=%h want 0/0", r_addr, r_data);
      end
      run_access(INST_LW, 32'h2008, 32'h0, 32'hCAFEF00D, 0);
      checks++;
      if (r_data !== 32'hCAFEF00D || r_we !== 0 || r_len !== LEN_WORD) begin
         errors++;
         $display("FAIL lw_data got=%h we=%b len=%b want cafef00d/0/10", r_data, r_we, r_len);
      end
   endtask

   task automatic test_busy;
      run_access(INST_LW, 32'h3000, 32'h0, 32'h01020304, 3);
      checks++;
      if (r_req_cyc != 4 || r_reqs != 1) begin
         errors++;
         $display("FAIL busy_req cycle=%0d reqs=%0d want 4/1", r_req_cyc, r_reqs);
      end
      checks++;
      if (r_stalls != 5 || r_data !== 32'h01020304) begin
         errors++;
         $display("FAIL busy_data stalls=%0d data=%h want 5/01020304", r_stalls, r_data);
      end
   endtask

   task automatic test_rdy_hold;
      @(posedge clk); #1;
      inst_in = INST_LW;
      mem_address_in = 32'h4000;
      rd_address_in = 5'd2;
      mem_rdata_in = 32'h11223344;
      @(negedge clk);
      checks++;
      if (mem_req_out !== 1) begin
         errors++;
         $display("FAIL rdy_issue req=%b want 1", mem_req_out);
      end
      @(posedge clk); #1;
      rdy_in = 0;
      mem_done_in = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req_out !== 1 || stall_req_out !== 1) begin
            errors++;
            $display("FAIL rdy_hold%0d req=%b stall=%b want 1/1", i, mem_req_out, stall_req_out);
         end
         @(posedge clk); #1;
         mem_done_in = 0;
      end
      rdy_in = 1;
      mem_done_in = 1;
      @(posedge clk); #1;
      mem_done_in = 0;
      @(negedge clk);
      checks++;
      if (stall_req_out !== 0 || mem_req_out !== 0 || rd_data_out !== 32'h11223344) begin
         errors++;
         $display("FAIL rdy_done stall=%b req=%b data=%h want 0/0/11223344",
                  stall_req_out, mem_req_out, rd_data_out);
      end
      @(posedge clk); #1;
      inst_in = INST_NOP;
   endtask

   task automatic test_reset_wait;
      @(posedge clk); #1;
      inst_in = INST_LW;
      mem_address_in = 32'h5000;
      rd_address_in = 5'd4;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_req_out !== 1 || stall_req_out !== 1) begin
         errors++;
         $display("FAIL rstw_wait req=%b stall=%b want 1/1", mem_req_out, stall_req_out);
      end
      #1;
      rst_in = 0;
      inst_in = INST_NOP;
      rd_data_in = 32'h55;
      #1;
      checks++;
      if (mem_req_out !== 0 || stall_req_out !== 0 || rd_data_out !== 0) begin
         errors++;
         $display("FAIL rstw_abort req=%b stall=%b data=%h want 0/0/0",
                  mem_req_out, stall_req_out, rd_data_out);
      end
      @(posedge clk); #1;
      rst_in = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_done_in = 1;
      mem_rdata_in = 32'h99;
      @(negedge clk);
      checks++;
      if (mem_req_out !== 0 || stall_req_out !== 0 || rd_data_out !== 32'h55) begin
         errors++;
         $display("FAIL rstw_late_done req=%b stall=%b data=%h want 0/0/55",
                  mem_req_out, stall_req_out, rd_data_out);
      end
      @(posedge clk); #1;
      mem_done_in = 0;
      run_access(INST_LW, 32'h5004, 32'h0, 32'h0BADF00D, 0);
      checks++;
      if (r_req_cyc != 1 || r_reqs != 1 || r_data !== 32'h0BADF00D) begin
         errors++;
         $display("FAIL rstw_after cycle=%0d reqs=%0d data=%h want 1/1/0badf00d",
                  r_req_cyc, r_reqs, r_data);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lb();
      test_half();
      test_word();
      test_busy();
      test_rdy_hold();
      test_reset_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
